// File: rtl/sddr_port_arbiter.sv
// sddr_port_arbiter: round-robin share of the sddr_ctrl data command port among NUM_PORTS requesters
//   cpu_clock_i/reset_n_i          clock, async active-low reset
//   req_valid_i/address/write/data per-port commands (flattened, port p in slice p)
//   req_ack_o                      one-hot: command of a port accepted this cycle
//   req_rsp_ready_o/req_rsp_data_o one-hot read-response pulse and shared read data
//   data_cmd_*_o / data_cmd_ack_i  command channel to sddr_ctrl
//   data_rsp_ready_i/data_rsp_data_i read response from sddr_ctrl
//   busy_o/owner_o                 state != IDLE / current or last granted port
//   timeout_o/clear_timeout_i      sticky lost-read flag and its clear
module sddr_port_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int ADDRESS_BITS = 27,
    parameter int DATA_WIDTH   = 128,
    parameter int RSP_TIMEOUT  = 1024,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CW = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1
) (
    input  logic                              cpu_clock_i,
    input  logic                              reset_n_i,
    input  logic [NUM_PORTS-1:0]              req_valid_i,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address_i,
    input  logic [NUM_PORTS-1:0]              req_write_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_PORTS-1:0]              req_ack_o,
    output logic [NUM_PORTS-1:0]              req_rsp_ready_o,
    output logic [DATA_WIDTH-1:0]             req_rsp_data_o,
    output logic                              data_cmd_valid_o,
    output logic [ADDRESS_BITS-1:0]           data_cmd_address_o,
    output logic                              data_cmd_write_o,
    output logic [DATA_WIDTH-1:0]             data_cmd_data_o,
    input  logic                              data_cmd_ack_i,
    input  logic                              data_rsp_ready_i,
    input  logic [DATA_WIDTH-1:0]             data_rsp_data_i,
    output logic                              busy_o,
    output logic [PW-1:0]                     owner_o,
    output logic                              timeout_o,
    input  logic                              clear_timeout_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
    state_t                  state_q;
    logic [PW-1:0]           owner_q, rr_ptr_q, grant_d, ptr_d;
    logic [CW-1:0]           counter_q;
    logic                    timeout_q;
    logic [NUM_PORTS-1:0]    rsp_ready_q, own_oh;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    issue, xfer, to_hit;
    logic [PW:0]             cand;
    logic [ADDRESS_BITS-1:0] addr_a [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   data_a [NUM_PORTS];
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_a[p] = req_address_i[p*ADDRESS_BITS +: ADDRESS_BITS];
        assign data_a[p] = req_data_i[p*DATA_WIDTH +: DATA_WIDTH];
    end
    // Scan downward so the candidate closest to rr_ptr (smallest offset) is the last one assigned.
    always_comb begin
        grant_d = owner_q;
        cand = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
            if (req_valid_i[cand[PW-1:0]]) grant_d = cand[PW-1:0];
        end
    end
    assign issue              = state_q == ISSUE;
    assign own_oh             = NUM_PORTS'(1) << owner_q;
    assign data_cmd_valid_o   = issue && req_valid_i[owner_q];
    assign xfer               = data_cmd_valid_o && data_cmd_ack_i;
    // Command buses are forced to zero outside ISSUE so nothing leaks while idle or waiting.
    assign data_cmd_address_o = issue ? addr_a[owner_q] : '0;
    assign data_cmd_write_o   = issue && req_write_i[owner_q];
    assign data_cmd_data_o    = issue ? data_a[owner_q] : '0;
    assign req_ack_o          = xfer ? own_oh : '0;
    assign ptr_d              = (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
    // A response arriving in the expiry cycle wins over the timeout.
    assign to_hit             = (RSP_TIMEOUT != 0) && (state_q == WAIT_RSP) && !data_rsp_ready_i
                                && (counter_q == CW'(1));
    assign busy_o             = state_q != IDLE;
    assign owner_o            = owner_q;
    assign timeout_o          = timeout_q;
    assign req_rsp_ready_o    = rsp_ready_q;
    assign req_rsp_data_o     = rsp_data_q;
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            counter_q   <= '0;
            timeout_q   <= 1'b0;
            rsp_ready_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_ready_q <= '0;
            timeout_q   <= to_hit ? 1'b1 : clear_timeout_i ? 1'b0 : timeout_q;
            case (state_q)
                IDLE: if (|req_valid_i) begin
                    owner_q <= grant_d;
                    state_q <= ISSUE;
                end
                ISSUE: if (!req_valid_i[owner_q]) begin
                    state_q <= IDLE;
                end else if (data_cmd_ack_i) begin
                    rr_ptr_q  <= ptr_d;
                    state_q   <= req_write_i[owner_q] ? IDLE : WAIT_RSP;
                    counter_q <= CW'(RSP_TIMEOUT);
                end
                WAIT_RSP: if (data_rsp_ready_i) begin
                    rsp_data_q  <= data_rsp_data_i;
                    rsp_ready_q <= own_oh;
                    state_q     <= IDLE;
                end else if (to_hit) begin
                    rsp_data_q  <= '0;
                    rsp_ready_q <= own_oh;
                    state_q     <= IDLE;
                end else if (RSP_TIMEOUT != 0) begin
                    counter_q <= counter_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sddr_port_arbiter.sv
// tb_sddr_port_arbiter: directed self-checking bench for sddr_port_arbiter
module tb_sddr_port_arbiter;
    localparam int NP = 2;
    localparam int AB = 27;
    localparam int DW = 128;
    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     valid, write;
    logic [NP*AB-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic              cmd_ack, rsp_in, clear_to;
    logic [DW-1:0]     rsp_in_data;
    logic [NP-1:0]     ack, rsp_rdy, t_ack, t_rsp_rdy;
    logic [DW-1:0]     rsp_data, cmd_data, t_rsp_data, t_cmd_data;
    logic              cmd_valid, cmd_write, busy, timeout;
    logic              t_cmd_valid, t_cmd_write, t_busy, t_timeout;
    logic [AB-1:0]     cmd_addr, t_cmd_addr;
    logic              owner, t_owner;
    int                n_checks = 0;
    int                n_fail = 0;
    always #5 clk = ~clk;
    sddr_port_arbiter #(.NUM_PORTS(NP), .ADDRESS_BITS(AB), .DATA_WIDTH(DW), .RSP_TIMEOUT(1024)) dut (
        .cpu_clock_i(clk), .reset_n_i(reset_n), .req_valid_i(valid), .req_address_i(addr),
        .req_write_i(write), .req_data_i(wdata), .req_ack_o(ack), .req_rsp_ready_o(rsp_rdy),
        .req_rsp_data_o(rsp_data), .data_cmd_valid_o(cmd_valid), .data_cmd_address_o(cmd_addr),
        .data_cmd_write_o(cmd_write), .data_cmd_data_o(cmd_data), .data_cmd_ack_i(cmd_ack),
        .data_rsp_ready_i(rsp_in), .data_rsp_data_i(rsp_in_data), .busy_o(busy), .owner_o(owner),
        .timeout_o(timeout), .clear_timeout_i(clear_to));
    sddr_port_arbiter #(.NUM_PORTS(NP), .ADDRESS_BITS(AB), .DATA_WIDTH(DW), .RSP_TIMEOUT(8)) dut_to (
        .cpu_clock_i(clk), .reset_n_i(reset_n), .req_valid_i(valid), .req_address_i(addr),
        .req_write_i(write), .req_data_i(wdata), .req_ack_o(t_ack), .req_rsp_ready_o(t_rsp_rdy),
        .req_rsp_data_o(t_rsp_data), .data_cmd_valid_o(t_cmd_valid), .data_cmd_address_o(t_cmd_addr),
        .data_cmd_write_o(t_cmd_write), .data_cmd_data_o(t_cmd_data), .data_cmd_ack_i(cmd_ack),
        .data_rsp_ready_i(rsp_in), .data_rsp_data_i(rsp_in_data), .busy_o(t_busy), .owner_o(t_owner),
        .timeout_o(t_timeout), .clear_timeout_i(clear_to));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_inputs();
        valid = '0; write = '0; addr = '0; wdata = '0;
        cmd_ack = 1'b0; rsp_in = 1'b0; clear_to = 1'b0; rsp_in_data = '0;
    endtask
    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask
    task automatic test_reset();
        clear_inputs();
        addr = {27'h0000444, 27'h0000333};
        wdata = {128'h1, 128'h2};
        #2 reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, owner, timeout, cmd_valid, cmd_write, ack, rsp_rdy} !== 9'b0)
            begin n_fail++; $display("FAIL reset_ctl: got busy=%b owner=%b to=%b cv=%b cw=%b ack=%b rr=%b, expected all 0", busy, owner, timeout, cmd_valid, cmd_write, ack, rsp_rdy); end
        n_checks++;
        if (cmd_addr !== '0 || cmd_data !== '0 || rsp_data !== '0)
            begin n_fail++; $display("FAIL reset_bus: got addr=%h data=%h rsp=%h, expected 0", cmd_addr, cmd_data, rsp_data); end
        n_checks++;
        if ({t_busy, t_timeout, t_rsp_rdy} !== 4'b0)
            begin n_fail++; $display("FAIL reset_to_dut: got busy=%b to=%b rr=%b, expected 0", t_busy, t_timeout, t_rsp_rdy); end
        reset_n = 1'b1;
        tick();
    endtask
    task automatic test_read_route();
        int bad = 0;
        apply_reset();
        addr[0 +: AB] = 27'h0001000;
        valid = 2'b01; write = 2'b00; cmd_ack = 1'b1;
        n_checks++;
        if (cmd_valid !== 1'b0)
            begin n_fail++; $display("FAIL rd_idle_noissue: got %b expected 0", cmd_valid); end
        tick();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 27'h0001000 || cmd_write !== 1'b0 || ack !== 2'b01)
            begin n_fail++; $display("FAIL rd_issue: got cv=%b addr=%h w=%b ack=%b expected 1 0001000 0 01", cmd_valid, cmd_addr, cmd_write, ack); end
        tick();
        valid = 2'b00;
        n_checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b1 || ack !== 2'b00)
            begin n_fail++; $display("FAIL rd_wait: got cv=%b busy=%b ack=%b expected 0 1 00", cmd_valid, busy, ack); end
        repeat (20) begin
            tick();
            if (ack !== 2'b00 || rsp_rdy !== 2'b00 || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0)
            begin n_fail++; $display("FAIL rd_wait_quiet: got %0d bad cycles expected 0", bad); end
        rsp_in = 1'b1; rsp_in_data = {16{8'hA5}};
        n_checks++;
        if (rsp_rdy !== 2'b00)
            begin n_fail++; $display("FAIL rd_rsp_early: got %b expected 00", rsp_rdy); end
        tick();
        rsp_in = 1'b0; rsp_in_data = '0;
        n_checks++;
        if (rsp_rdy !== 2'b01 || rsp_data !== {16{8'hA5}} || busy !== 1'b0)
            begin n_fail++; $display("FAIL rd_rsp: got rr=%b data=%h busy=%b expected 01 a5.. 0", rsp_rdy, rsp_data, busy); end
        tick();
        n_checks++;
        if (rsp_rdy !== 2'b00 || rsp_data !== {16{8'hA5}})
            begin n_fail++; $display("FAIL rd_rsp_pulse: got rr=%b data=%h expected 00 a5..", rsp_rdy, rsp_data); end
    endtask
    task automatic test_round_robin();
        logic [AB-1:0] ea;
        logic [DW-1:0] ed;
        apply_reset();
        addr = {27'h0000200, 27'h0000100};
        wdata = {{16{8'h22}}, {16{8'h11}}};
        valid = 2'b11; write = 2'b11; cmd_ack = 1'b1;
        for (int g = 0; g < 4; g++) begin
            ea = (g % 2 == 1) ? 27'h0000200 : 27'h0000100;
            ed = (g % 2 == 1) ? {16{8'h22}} : {16{8'h11}};
            tick();
            n_checks++;
            if (ack !== ((g % 2 == 1) ? 2'b10 : 2'b01) || cmd_addr !== ea || cmd_data !== ed || cmd_write !== 1'b1)
                begin n_fail++; $display("FAIL rr_grant%0d: got ack=%b addr=%h data=%h w=%b expected port %0d", g, ack, cmd_addr, cmd_data, cmd_write, g % 2); end
            tick();
            n_checks++;
            if (ack !== 2'b00 || busy !== 1'b0)
                begin n_fail++; $display("FAIL rr_gap%0d: got ack=%b busy=%b expected 00 0", g, ack, busy); end
        end
        valid = 2'b00;
        tick();
    endtask
    task automatic test_one_outstanding();
        int bad = 0;
        apply_reset();
        addr = {27'h0000222, 27'h0000111};
        valid = 2'b10; write = 2'b00; cmd_ack = 1'b1;
        tick();
        n_checks++;
        if (ack !== 2'b10 || owner !== 1'b1 || cmd_addr !== 27'h0000222)
            begin n_fail++; $display("FAIL oo_p1_issue: got ack=%b owner=%b addr=%h expected 10 1 0000222", ack, owner, cmd_addr); end
        tick();
        valid = 2'b01; write = 2'b01;
        repeat (5) begin
            tick();
            if (cmd_valid !== 1'b0 || ack !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0)
            begin n_fail++; $display("FAIL oo_blocked: got %0d issuing cycles expected 0", bad); end
        rsp_in = 1'b1; rsp_in_data = {16{8'h77}};
        tick();
        rsp_in = 1'b0;
        n_checks++;
        if (rsp_rdy !== 2'b10 || rsp_data !== {16{8'h77}} || cmd_valid !== 1'b0)
            begin n_fail++; $display("FAIL oo_p1_rsp: got rr=%b data=%h cv=%b expected 10 77.. 0", rsp_rdy, rsp_data, cmd_valid); end
        tick();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_write !== 1'b1 || ack !== 2'b01 || cmd_addr !== 27'h0000111)
            begin n_fail++; $display("FAIL oo_p0_issue: got cv=%b w=%b ack=%b addr=%h expected 1 1 01 0000111", cmd_valid, cmd_write, ack, cmd_addr); end
        tick();
        valid = 2'b00;
        tick();
    endtask
    task automatic test_timeout();
        int bad = 0;
        apply_reset();
        valid = 2'b01; write = 2'b00; cmd_ack = 1'b1;
        tick();
        tick();
        valid = 2'b00;
        tick();
        rsp_in = 1'b1; rsp_in_data = {16{8'h5A}};
        tick();
        rsp_in = 1'b0;
        n_checks++;
        if (t_rsp_rdy !== 2'b01 || t_rsp_data !== {16{8'h5A}})
            begin n_fail++; $display("FAIL to_pre_rsp: got rr=%b data=%h expected 01 5a..", t_rsp_rdy, t_rsp_data); end
        valid = 2'b10;
        tick();
        tick();
        valid = 2'b00;
        repeat (7) begin
            tick();
            if (t_rsp_rdy !== 2'b00 || t_timeout !== 1'b0 || t_busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0)
            begin n_fail++; $display("FAIL to_early: got %0d early-expiry cycles expected 0", bad); end
        tick();
        n_checks++;
        if (t_timeout !== 1'b1 || t_rsp_rdy !== 2'b10 || t_rsp_data !== '0 || t_busy !== 1'b0)
            begin n_fail++; $display("FAIL to_expire: got to=%b rr=%b data=%h busy=%b expected 1 10 0 0", t_timeout, t_rsp_rdy, t_rsp_data, t_busy); end
        rsp_in = 1'b1; rsp_in_data = {16{8'hFF}};
        tick();
        rsp_in = 1'b0;
        n_checks++;
        if (t_rsp_rdy !== 2'b00 || t_rsp_data !== '0 || t_timeout !== 1'b1)
            begin n_fail++; $display("FAIL to_late_rsp: got rr=%b data=%h to=%b expected 00 0 1", t_rsp_rdy, t_rsp_data, t_timeout); end
        clear_to = 1'b1;
        tick();
        clear_to = 1'b0;
        n_checks++;
        if (t_timeout !== 1'b0)
            begin n_fail++; $display("FAIL to_clear: got %b expected 0", t_timeout); end
    endtask
    task automatic test_rsp_vs_expiry();
        apply_reset();
        valid = 2'b01; write = 2'b00; cmd_ack = 1'b1;
        tick();
        tick();
        valid = 2'b00;
        repeat (7) tick();
        rsp_in = 1'b1; rsp_in_data = {16{8'hC3}};
        tick();
        rsp_in = 1'b0;
        n_checks++;
        if (t_rsp_rdy !== 2'b01 || t_rsp_data !== {16{8'hC3}} || t_timeout !== 1'b0 || t_busy !== 1'b0)
            begin n_fail++; $display("FAIL tie_rsp_wins: got rr=%b data=%h to=%b busy=%b expected 01 c3.. 0 0", t_rsp_rdy, t_rsp_data, t_timeout, t_busy); end
        tick();
        n_checks++;
        if (t_timeout !== 1'b0)
            begin n_fail++; $display("FAIL tie_no_timeout: got %b expected 0", t_timeout); end
    endtask
    task automatic test_reset_midflight();
        apply_reset();
        valid = 2'b10; write = 2'b00; cmd_ack = 1'b1;
        tick();
        tick();
        valid = 2'b00;
        rsp_in = 1'b1; rsp_in_data = {16{8'h33}};
        tick();
        rsp_in = 1'b0;
        valid = 2'b01;
        tick();
        tick();
        valid = 2'b00;
        tick();
        n_checks++;
        if (busy !== 1'b1 || rsp_data !== {16{8'h33}})
            begin n_fail++; $display("FAIL mr_pre: got busy=%b data=%h expected 1 33..", busy, rsp_data); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, owner, timeout, cmd_valid, ack, rsp_rdy} !== 8'b0 || rsp_data !== '0)
            begin n_fail++; $display("FAIL mr_async: got busy=%b owner=%b to=%b cv=%b ack=%b rr=%b data=%h expected all 0", busy, owner, timeout, cmd_valid, ack, rsp_rdy, rsp_data); end
        tick();
        reset_n = 1'b1;
        valid = 2'b11; write = 2'b11;
        tick();
        n_checks++;
        if (owner !== 1'b0 || ack !== 2'b01)
            begin n_fail++; $display("FAIL mr_rrptr: got owner=%b ack=%b expected 0 01", owner, ack); end
        valid = 2'b00;
        tick();
    endtask
    initial begin
        reset_n = 1'b1;
        test_reset();
        test_read_route();
        test_round_robin();
        test_one_outstanding();
        test_timeout();
        test_rsp_vs_expiry();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
